// File: rtl/gray_counter_n_pkg.sv
// Shared definitions for the parametrised Gray-code counter family.
// Provides the binary-to-Gray helper, direction constants and the
// per-edge operation encoding used by gray_counter_n.
// Optional build macro honoured by gray_counter_n: GRAY_SATURATE_EN.

package gray_pkg;

    // Widest counter supported by the helper functions below.
    localparam int GRAY_MAX_WIDTH = 16;

    // Dir input encoding.
    localparam logic GRAY_DIR_UP   = 1'b0;
    localparam logic GRAY_DIR_DOWN = 1'b1;

    // What the counter does on a given rising edge, in priority order.
    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_UP   = 2'd2,
        OP_DOWN = 2'd3
    } gray_op_e;

    // Binary to reflected Gray code. Callers zero-extend their value to
    // GRAY_MAX_WIDTH and keep the low bits of the result; the zero fill
    // makes the top Gray bit equal the top binary bit as required.
    function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(
        input logic [GRAY_MAX_WIDTH-1:0] x
    );
        return x ^ (x >> 1);
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter.
// Each binary bit is the XOR of all Gray bits at or above its position,
// so there is no feedback inside the always-free prefix network.
// Kept standalone so pointer synchronisers can reuse it.

module gray_to_bin #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_prefix
            assign bin_o[i] = ^gray_i[WIDTH-1:i];
        end
    endgenerate

endmodule

// File: rtl/gray_counter_n.sv
// Parametrised up/down Gray-code counter with Gray-coded load,
// sticky Overflow flag (software clear) and a one-cycle Wrap pulse.
// Output comes straight from a register so it is glitch-free.
// Build macro GRAY_SATURATE_EN: when defined the count saturates at
// all-ones / zero instead of wrapping; the blocked step still raises
// Wrap and Overflow. Undefined (default): modulo 2^WIDTH counting.

module gray_counter_n
    import gray_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int INIT  = 0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Dir,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    input  logic             OvfClr,
    output logic [WIDTH-1:0] Output,
    output logic [WIDTH-1:0] BinOut,
    output logic             Wrap,
    output logic             Overflow
);

    localparam logic [WIDTH-1:0] INIT_BIN  = INIT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] INIT_GRAY = INIT_BIN ^ (INIT_BIN >> 1);
    localparam logic [WIDTH-1:0] ALL_ONES  = '1;
    localparam logic [WIDTH-1:0] ALL_ZERO  = '0;
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    logic [WIDTH-1:0] bin_q,  bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q,  ovf_d;

    logic [WIDTH-1:0]          loadBin;
    logic [GRAY_MAX_WIDTH-1:0] grayWide;
    gray_op_e                  op;
    logic                      wrapEvent;

    // Load value arrives in Gray code; convert it once for the binary register.
    gray_to_bin #(
        .WIDTH (WIDTH)
    ) u_load_conv (
        .gray_i (LoadVal),
        .bin_o  (loadBin)
    );

    // Pick this edge's operation: load beats enable, enable then uses Dir.
    always_comb begin
        op = OP_HOLD;
        if (Load) begin
            op = OP_LOAD;
        end else if (En) begin
            op = (Dir == GRAY_DIR_DOWN) ? OP_DOWN : OP_UP;
        end
    end

    // A wrap event is a step off either end of the range; loads never wrap.
    always_comb begin
        wrapEvent = 1'b0;
        case (op)
            OP_UP:   wrapEvent = (bin_q == ALL_ONES);
            OP_DOWN: wrapEvent = (bin_q == ALL_ZERO);
            default: wrapEvent = 1'b0;
        endcase
    end

    // Next binary count; the saturating build refuses to step past the ends.
    always_comb begin
        bin_d = bin_q;
        case (op)
            OP_LOAD: bin_d = loadBin;
`ifdef GRAY_SATURATE_EN
            OP_UP:   bin_d = wrapEvent ? bin_q : bin_q + ONE;
            OP_DOWN: bin_d = wrapEvent ? bin_q : bin_q - ONE;
`else
            OP_UP:   bin_d = bin_q + ONE;
            OP_DOWN: bin_d = bin_q - ONE;
`endif
            default: bin_d = bin_q;
        endcase
    end

    // Gray register tracks the next binary value so both update together.
    always_comb begin
        grayWide = bin2gray(GRAY_MAX_WIDTH'(bin_d));
        gray_d   = grayWide[WIDTH-1:0];
    end

    // Wrap pulses for one cycle per event; Overflow set takes priority over clear.
    always_comb begin
        wrap_d = wrapEvent;
        ovf_d  = ovf_q;
        if (wrapEvent) begin
            ovf_d = 1'b1;
        end else if (OvfClr) begin
            ovf_d = 1'b0;
        end
    end

    // State registers; async reset drops everything back to INIT at once.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            bin_q  <= INIT_BIN;
            gray_q <= INIT_GRAY;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    assign Output   = gray_q;
    assign BinOut   = bin_q;
    assign Wrap     = wrap_q;
    assign Overflow = ovf_q;

endmodule

// File: tb/tb_gray_counter_n.sv
// Directed test of gray_counter_n (WIDTH=3, INIT=0, default modulo build).
// Inputs change 2 ns after each rising edge; outputs are checked there too.

module tb_gray_counter_n;

   logic       Clk;
   logic       Reset;
   logic       En;
   logic       Dir;
   logic       Load;
   logic [2:0] LoadVal;
   logic       OvfClr;
   logic [2:0] Output;
   logic [2:0] BinOut;
   logic       Wrap;
   logic       Overflow;

   int checks;
   int errors;

   gray_counter_n #(
      .WIDTH (3),
      .INIT  (0)
   ) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .En       (En),
      .Dir      (Dir),
      .Load     (Load),
      .LoadVal  (LoadVal),
      .OvfClr   (OvfClr),
      .Output   (Output),
      .BinOut   (BinOut),
      .Wrap     (Wrap),
      .Overflow (Overflow)
   );

   // Free-running 10 ns clock, rising edges at 5, 15, 25 ...
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Hard stop in case the run ever stalls.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkAll(input string tag, input logic [2:0] gray,
                           input logic [2:0] bin, input logic wrap,
                           input logic ovf);
      checkOutput({tag, "_gray"}, 16'(Output),   16'(gray));
      checkOutput({tag, "_bin"},  16'(BinOut),   16'(bin));
      checkOutput({tag, "_wrap"}, 16'(Wrap),     16'(wrap));
      checkOutput({tag, "_ovf"},  16'(Overflow), 16'(ovf));
   endtask

   task automatic applyStimulus(input logic en, input logic dir,
                                input logic load, input logic [2:0] loadVal,
                                input logic ovfClr);
      En      = en;
      Dir     = dir;
      Load    = load;
      LoadVal = loadVal;
      OvfClr  = ovfClr;
      @(posedge Clk);
      #2;
   endtask

   logic [2:0] upGray [8];
   logic [2:0] upBin  [8];

   initial begin
      checks  = 0;
      errors  = 0;
      Reset   = 1'b0;
      En      = 1'b0;
      Dir     = 1'b0;
      Load    = 1'b0;
      LoadVal = 3'b000;
      OvfClr  = 1'b0;

      upGray = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
      upBin  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

      // Reset state before any clock edge
      #3;
      checkAll("reset", 3'b000, 3'd0, 1'b0, 1'b0);
      #17;
      Reset = 1'b1;

      // Up count through a full cycle and across the wrap
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
         checkAll($sformatf("up%0d", i), upGray[i], upBin[i], (i == 7), (i == 7));
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
      checkAll("up_after_wrap", 3'b001, 3'd1, 1'b0, 1'b1);

      // Reset again, then count down from zero
      Reset = 1'b0;
      #1;
      checkAll("rst2", 3'b000, 3'd0, 1'b0, 1'b0);
      Reset = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
      checkAll("dn0", 3'b100, 3'd7, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
      checkAll("dn1", 3'b101, 3'd6, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
      checkAll("dn2", 3'b111, 3'd5, 1'b0, 1'b1);

      // Software clear of the sticky flag while holding
      applyStimulus(1'b0, 1'b1, 1'b0, 3'b000, 1'b1);
      checkAll("ovfclr", 3'b111, 3'd5, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
      checkAll("hold", 3'b111, 3'd5, 1'b0, 1'b0);

      // Load has priority over enable; then resume counting up
      applyStimulus(1'b1, 1'b0, 1'b1, 3'b110, 1'b0);
      checkAll("load", 3'b110, 3'd4, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
      checkAll("load_up", 3'b111, 3'd5, 1'b0, 1'b0);

      // Direction change applies from the very next edge
      applyStimulus(1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
      checkAll("dirchg", 3'b110, 3'd4, 1'b0, 1'b0);

      // Load all-ones, then wrap and clear in the same cycle: set wins
      applyStimulus(1'b0, 1'b0, 1'b1, 3'b100, 1'b0);
      checkAll("load7", 3'b100, 3'd7, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 1'b1);
      checkAll("setwins", 3'b000, 3'd0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
      checkAll("wrap_one", 3'b000, 3'd0, 1'b0, 1'b1);

      // Asynchronous reset in the middle of counting
      applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
      checkAll("pre_rst0", 3'b001, 3'd1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
      checkAll("pre_rst1", 3'b011, 3'd2, 1'b0, 1'b1);
      #3;
      Reset = 1'b0;
      #1;
      checkAll("async_rst", 3'b000, 3'd0, 1'b0, 1'b0);
      #1;
      Reset = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
      checkAll("resume", 3'b001, 3'd1, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gray_counter_n.md
Name: gray_counter_n

Overview:
Parametrised Gray-code counter and the successor to the fixed 3-bit Gray counter. Width is configurable, counting goes up or down, and the counter can be loaded in Gray code. It provides a sticky Overflow flag with software clear and a one-cycle Wrap pulse. Used as a glitch-free pointer/sequence source for later FIFO and handshake blocks.

Parameters:
WIDTH, 3, counter width in bits (2..16)
INIT, 0, binary reset value of the count; Gray output resets to bin2gray(INIT)

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  asynchronous, active-low reset (0 = reset)
En  input  1  count enable
Dir  input  1  0 = count up, 1 = count down
Load  input  1  synchronous load, priority over En
LoadVal  input  WIDTH  value to load, in Gray code
OvfClr  input  1  synchronous clear of the sticky Overflow flag
Output  output  WIDTH  current count, Gray code, driven straight from a register
BinOut  output  WIDTH  current count, binary, registered
Wrap  output  1  one-cycle pulse in the cycle after a wrap
Overflow  output  1  sticky wrap flag

Behaviour:
- Reset (Reset=0, async):
  - bin_q=INIT, Output=bin2gray(INIT), BinOut=INIT, Wrap=0, Overflow=0.
  - Reset applied mid-count aborts immediately; no pending load or wrap survives it.
- Internal state: binary register bin_q and Gray register gray_q.
  - gray_q is loaded with bin2gray(bin_next) on every update, so Output never has combinational glitches.
- Next-state priority, per rising edge:
  1. Load=1: bin_next=gray2bin(LoadVal). No wrap. Wrap=0. Overflow unchanged (except by OvfClr).
  2. else En=1, Dir=0: bin_next=bin_q+1 modulo 2^WIDTH. Wrap event when bin_q = all-ones.
  3. else En=1, Dir=1: bin_next=bin_q-1 modulo 2^WIDTH. Wrap event when bin_q = 0.
  4. else: hold. Wrap=0.
- Latency: Output/BinOut reflect the new value one cycle after the enabling edge.
- Wrap: registered. It is 1 for exactly the one cycle after a wrap event; consecutive wraps give consecutive pulses.
- Overflow:
  - Set on a wrap event.
  - Cleared by OvfClr=1.
  - Simultaneous wrap event and OvfClr: set wins, Overflow=1.
- Arithmetic is WIDTH bits, unsigned, with no carry out beyond Wrap.
- Dir may change on any cycle; the new direction applies from that edge.
- Adjacent Output values differ in exactly one bit in both directions, including across the wrap.

Optional Feature:
Macro GRAY_SATURATE_EN.
- Defined:
  - Up-count holds at all-ones; down-count holds at 0.
  - The "wrap event" becomes a saturation attempt: Overflow sets and Wrap pulses, but the count does not change.
  - Load still works normally.
- Undefined: modulo wrap exactly as described in Behaviour.

Decomposition:
- Package gray_pkg:
  - function bin2gray(x) = x ^ (x>>1)
  - constant GRAY_DIR_UP=0, GRAY_DIR_DOWN=1
- Sub-module gray_to_bin (parametrised WIDTH, combinational prefix-XOR):
  - Converts LoadVal to binary.
  - Reused later by FIFO pointer synchronisers.

Test Plan:
1. WIDTH=3, INIT=0, Reset low for 20 ns then high, En=1, Dir=0 -> Output sequence 000,001,011,010,110,111,101,100,000. Wrap pulses one cycle with Output=000; Overflow=1 from then on.
2. Same setup, Dir=1 from reset -> Output 000,100,101,111,... Wrap/Overflow set on the 0->7 step. OvfClr for one cycle -> Overflow=0 until the next wrap.
3. Load=1, LoadVal=110 (binary 4) with En=1 -> next cycle Output=110, BinOut=100, no Wrap. Following cycle up-count -> Output=111.
4. At BinOut=7, En=1, Dir=0, OvfClr=1 in the same cycle -> Output=000, Overflow=1 (set wins), Wrap=1.
5. Assert Reset=0 asynchronously mid-cycle during counting -> Output=000, Overflow=0, Wrap=0 immediately, without waiting for a clock edge. Counting resumes after Reset=1.
6. With GRAY_SATURATE_EN, WIDTH=3, up-count past 7 -> Output holds at 100, Overflow=1, Wrap pulses once per attempted increment.
